// File: rtl/cgra_sram_stream_master.sv
// Streams a bank range out on valid/ready or fills it with a constant word; first req 1 cycle after start.
// Reads are credit-gated against a 2-entry output FIFO, so ready_i backpressure never stalls returning rdata.
module cgra_sram_stream_master #(
  parameter int unsigned NumWords = 1024,
  localparam int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth:0]   len_i,
  input  logic [31:0]          fill_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [31:0]          wdata_o,
  output logic [3:0]           be_o,
  output logic                 set_retentive_o,
  input  logic [31:0]          rdata_i,
  output logic [31:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StFill  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]           state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth:0]   issue_cnt_q;
  logic [AddrWidth:0]   len_q;
  logic [31:0]          fill_q;
  logic                 inflight_q;

  logic [31:0]          fifo_mem_q [2];
  logic                 fifo_wr_ptr_q;
  logic                 fifo_rd_ptr_q;
  logic [1:0]           fifo_cnt_q;

  logic                 pop;
  logic [2:0]           pending;
  logic                 credit_ok;
  logic                 rd_issue;
  logic                 wr_issue;
  logic                 last_issue;
  logic                 drain_done;

  assign pop       = valid_o & ready_i;
  // Words already owed to the stream (buffered or returning next cycle) must leave room for one more.
  assign pending   = 3'(fifo_cnt_q) + 3'(inflight_q);
  assign credit_ok = pending < (3'd2 + 3'(pop));
  assign rd_issue  = (state_q == StRead) & credit_ok;
  assign wr_issue  = (state_q == StFill);
  assign last_issue = (issue_cnt_q == (len_q - 1'b1));
  // Finish in the cycle the last word leaves, not one cycle later.
  assign drain_done = ~inflight_q & (fifo_cnt_q == {1'b0, pop});

  assign req_o           = rd_issue | wr_issue;
  assign we_o            = wr_issue;
  assign addr_o          = req_o ? addr_q : '0;
  assign wdata_o         = wr_issue ? fill_q : 32'h0;
  assign be_o            = wr_issue ? 4'hF : 4'h0;
  assign set_retentive_o = 1'b0;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StDone);

  assign valid_o = (fifo_cnt_q != 2'd0);
  assign data_o  = fifo_mem_q[fifo_rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      len_q       <= '0;
      fill_q      <= 32'h0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            addr_q      <= base_addr_i;
            issue_cnt_q <= '0;
            len_q       <= len_i;
            fill_q      <= fill_data_i;
            if (len_i == '0) begin
              state_q <= StDone;
            end else if (mode_i) begin
              state_q <= StFill;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (rd_issue) begin
            addr_q      <= addr_q + 1'b1;
            issue_cnt_q <= issue_cnt_q + 1'b1;
            if (last_issue) begin
              state_q <= StDrain;
            end
          end
        end
        StFill: begin
          addr_q      <= addr_q + 1'b1;
          issue_cnt_q <= issue_cnt_q + 1'b1;
          if (last_issue) begin
            state_q <= StDone;
          end
        end
        StDrain: begin
          if (drain_done) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Returning rdata is always accepted; the issue credit guarantees a free slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_mem_q[0] <= 32'h0;
      fifo_mem_q[1] <= 32'h0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_mem_q[fifo_wr_ptr_q] <= rdata_i;
        fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
      end
      if (pop) begin
        fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end
      case ({inflight_q, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_sram_stream_master.sv
// Bench for cgra_sram_stream_master: SRAM bank model, queue-based reference model and per-cycle compare.
module tb_cgra_sram_stream_master;
  localparam int NW = 1024;
  localparam int AW = 10;
  localparam int IDLE_FROM = 32'h3fffffff;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          mode_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   len_i;
  logic [31:0]   fill_data_i;
  logic          busy_o, done_o, req_o, we_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic [3:0]    be_o;
  logic          set_retentive_o;
  logic [31:0]   rdata_i = 32'h0;
  logic [31:0]   data_o;
  logic          valid_o;
  logic          ready_i;

  cgra_sram_stream_master #(.NumWords(NW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .fill_data_i(fill_data_i),
    .busy_o(busy_o), .done_o(done_o), .req_o(req_o), .we_o(we_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .set_retentive_o(set_retentive_o), .rdata_i(rdata_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: byte-enabled write, registered read.
  logic [31:0] sram [NW];
  always @(posedge clk) begin
    if (req_o) begin
      if (we_o) begin
        for (int b = 0; b < 4; b++)
          if (be_o[b]) sram[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
      end else begin
        rdata_i <= sram[addr_o];
      end
    end
  end

  // Reference model state.
  logic [31:0]   gm [NW];
  logic [31:0]   exp_stream [$];
  logic [AW-1:0] exp_rd_addr [$];
  logic [AW-1:0] exp_wr_addr [$];
  logic [31:0]   exp_wr_dat [$];
  int            exp_done = -1;
  int            busy_from = IDLE_FROM;
  int            busy_to = -1;
  bit            op_is_read = 1'b0;
  int            outstanding = 0;
  bit            run_chk = 1'b0;

  logic [31:0]   got [$];
  int            pop_cyc [$];
  int            req_cyc [$];
  int            last_done_cyc = -1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_cmd(input bit mode, input int base, input int len,
                           input logic [31:0] fill, input int t);
    int a;
    busy_from  = t + 1;
    op_is_read = 1'b0;
    if (len == 0) begin
      exp_done = t + 1;
      busy_to  = t + 1;
    end else if (mode) begin
      for (int i = 0; i < len; i++) begin
        a = (base + i) % NW;
        exp_wr_addr.push_back(a[AW-1:0]);
        exp_wr_dat.push_back(fill);
        gm[a] = fill;
      end
      exp_done = t + len + 1;
      busy_to  = exp_done;
    end else begin
      for (int i = 0; i < len; i++) begin
        a = (base + i) % NW;
        exp_rd_addr.push_back(a[AW-1:0]);
        exp_stream.push_back(gm[a]);
      end
      exp_done   = -1;
      busy_to    = -1;
      op_is_read = 1'b1;
    end
  endtask

  // Per-cycle compare against the model.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_dat;
  bit          busy_exp, issue, popped;
  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      busy_exp = (cyc >= busy_from) && (busy_to < 0 || cyc <= busy_to);
      check("busy", busy_o, busy_exp);
      check("done", done_o, cyc == exp_done);
      if (done_o) last_done_cyc = cyc;
      check("set_retentive", set_retentive_o, 0);
      if (!req_o) begin
        check("idle_bus", {we_o, addr_o, wdata_o, be_o}, 0);
      end else if (we_o) begin
        check("write_expected", exp_wr_addr.size() != 0, 1);
        if (exp_wr_addr.size() != 0) begin
          check("wr_addr", addr_o, exp_wr_addr.pop_front());
          check("wr_data", wdata_o, exp_wr_dat.pop_front());
          check("wr_be", be_o, 4'hF);
        end
      end else begin
        check("read_expected", exp_rd_addr.size() != 0, 1);
        if (exp_rd_addr.size() != 0) begin
          check("rd_addr", addr_o, exp_rd_addr.pop_front());
          check("rd_be", be_o, 0);
        end
      end
      if (req_o) req_cyc.push_back(cyc);
      if (prev_stall) begin
        check("hold_valid", valid_o, 1);
        check("hold_data", data_o, prev_dat);
      end
      issue  = req_o && !we_o;
      popped = valid_o && ready_i;
      outstanding = outstanding + int'(issue) - int'(popped);
      check("outstanding_le_2", outstanding <= 2, 1);
      if (popped) begin
        check("stream_expected", exp_stream.size() != 0, 1);
        if (exp_stream.size() != 0) begin
          check("stream_data", data_o, exp_stream.pop_front());
          got.push_back(data_o);
          pop_cyc.push_back(cyc);
          if (exp_stream.size() == 0 && op_is_read) begin
            exp_done = cyc + 1;
            busy_to  = cyc + 1;
          end
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_dat   = data_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Ready driver: held high, or a fixed stall pattern followed by random stalls.
  int rdy_mode = 0;
  initial begin
    int k;
    logic [3:0] pat;
    pat = 4'b1001;
    k = 0;
    ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        ready_i = 1'b1;
        k = 0;
      end else begin
        ready_i = (k < 4) ? pat[3 - k] : ($urandom_range(0, 2) != 0);
        k++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds start for the current cycle only.
  task automatic start_cmd(input bit mode, input int base, input int len,
                           input logic [31:0] fill, output int t);
    start_i     = 1'b1;
    mode_i      = mode;
    base_addr_i = base[AW-1:0];
    len_i       = len[AW:0];
    fill_data_i = fill;
    t = cyc;
    model_cmd(mode, base, len, fill, t);
    @(posedge clk); #1;
    start_i = 1'b0; mode_i = 1'b0; base_addr_i = '0; len_i = '0; fill_data_i = 32'h0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", n < budget, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    got.delete(); pop_cyc.delete(); req_cyc.delete();
    last_done_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_req"}, req_o, 0);
    check({tag, "_we"}, we_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_addr"}, addr_o, 0);
    check({tag, "_wdata"}, wdata_o, 0);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_be"}, be_o, 0);
    check({tag, "_retentive"}, set_retentive_o, 0);
  endtask

  initial begin
    int t;
    logic [31:0] lit4 [4];
    logic [31:0] lit6 [6];
    rst_n = 1'b0;
    start_i = 1'b0; mode_i = 1'b0; base_addr_i = '0; len_i = '0; fill_data_i = 32'h0;
    for (int a = 0; a < NW; a++) begin
      sram[a] = a * 3;
      gm[a]   = a * 3;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_chk = 1'b1;
    tick(2);

    // Read 0x010..0x013 with ready held high.
    lit4[0] = 32'h30; lit4[1] = 32'h33; lit4[2] = 32'h36; lit4[3] = 32'h39;
    clear_log();
    start_cmd(1'b0, 'h010, 4, 32'h0, t);
    wait_done(50);
    check("t1_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check("t1_word", got[i], lit4[i]);
      check("t1_word_cycle", pop_cyc[i], t + 3 + i);
    end
    check("t1_done_cycle", last_done_cyc, t + 7);
    check("t1_req_count", req_cyc.size(), 4);
    if (req_cyc.size() == 4) begin
      check("t1_first_req", req_cyc[0], t + 1);
      check("t1_last_req", req_cyc[3], t + 4);
    end

    // Same read under stalls; issued back-to-back after DONE.
    rdy_mode = 1;
    clear_log();
    start_cmd(1'b0, 'h010, 4, 32'h0, t);
    wait_done(200);
    rdy_mode = 0;
    check("t2_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t2_word", got[i], lit4[i]);
    tick(2);

    // Fill wrapping over the top of the bank, then read back with neighbours.
    clear_log();
    start_cmd(1'b1, NW - 2, 4, 32'hDEADBEEF, t);
    wait_done(50);
    check("t3_done_cycle", last_done_cyc, t + 5);
    check("t3_req_count", req_cyc.size(), 4);
    if (req_cyc.size() == 4) begin
      check("t3_first_req", req_cyc[0], t + 1);
      check("t3_last_req", req_cyc[3], t + 4);
    end
    lit6[0] = 32'h00000BF7; lit6[1] = 32'hDEADBEEF; lit6[2] = 32'hDEADBEEF;
    lit6[3] = 32'hDEADBEEF; lit6[4] = 32'hDEADBEEF; lit6[5] = 32'h00000006;
    clear_log();
    start_cmd(1'b0, NW - 3, 6, 32'h0, t);
    wait_done(60);
    check("t3_rb_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("t3_readback", got[i], lit6[i]);
    tick(1);

    // Zero-length command.
    clear_log();
    start_cmd(1'b0, 5, 0, 32'h0, t);
    wait_done(10);
    check("t4_done_cycle", last_done_cyc, t + 1);
    check("t4_no_req", req_cyc.size(), 0);

    // Start while busy is ignored.
    clear_log();
    start_cmd(1'b0, 'h100, 8, 32'h0, t);
    tick(1);
    start_i = 1'b1; mode_i = 1'b1; base_addr_i = 10'h200; len_i = 11'd3; fill_data_i = 32'h12345678;
    tick(1);
    start_i = 1'b0; mode_i = 1'b0; base_addr_i = '0; len_i = '0; fill_data_i = 32'h0;
    wait_done(80);
    check("t5_count", got.size(), 8);
    if (got.size() == 8) check("t5_last_word", got[7], 32'h315);
    check("t5_req_count", req_cyc.size(), 8);
    check("t5_untouched", sram['h200], 32'h600);
    check("t5_done_cycle", last_done_cyc, t + 11);
    tick(2);

    // Reset in the middle of a 16-word read, then a clean 2-word read.
    clear_log();
    start_cmd(1'b0, 'h040, 16, 32'h0, t);
    tick(5);
    #2;
    run_chk = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_stream.delete(); exp_rd_addr.delete(); exp_wr_addr.delete(); exp_wr_dat.delete();
    outstanding = 0; exp_done = -1; busy_from = IDLE_FROM; busy_to = -1; op_is_read = 1'b0;
    tick(2);
    rst_n = 1'b1;
    run_chk = 1'b1;
    tick(2);
    clear_log();
    start_cmd(1'b0, 'h050, 2, 32'h0, t);
    wait_done(40);
    check("t6_count", got.size(), 2);
    if (got.size() == 2) begin
      check("t6_word0", got[0], 32'hF0);
      check("t6_word1", got[1], 32'hF3);
    end
    check("t6_done_cycle", last_done_cyc, t + 5);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
